spmmio_uart: RTL
================

# spmmio_uart

Memory-mapped 8N1 UART peripheral for the service-processor MMIO space, occupying decode slot 8'h02 of the spmmio bus decoder beside the misc and SD card peripherals. It consumes the decoder's per-slot chip-select, word address, byte selects and write data, and returns read data combinationally in the same cycle, because the decoder acknowledges every strobe immediately. It provides TX and RX FIFOs, a programmable baud divisor, sticky error flags and a level interrupt.

## Interface
- FIFO_LOG2, 4: log2 of the depth of each FIFO (depth 16 by default); legal range 1..7.
- DIV_RESET, 433: reset value of the baud divisor; 433 gives 115200 baud at 50 MHz.
- clk  in  1  system clock; the block uses only this one clock.
- reset  in  1  synchronous, active-high reset.
- adr  in  [0:3]  word address; adr[3] is the LSB.
- cs  in  1  access strobe; each cycle with cs high is one access.
- sel  in  [0:3]  byte selects; sel[0] covers d[0:7] (MSB byte) and sel[3] covers d[24:31].
- we  in  1  1 = write, 0 = read.
- d  in  [0:31]  write data; bit 31 is the LSB.
- q  out  [0:31]  read data; combinational from adr and registered state, independent of cs.
- uart_txd  out  1  serial output; idles high.
- uart_rxd  in  1  asynchronous serial input.
- irq  out  1  level interrupt, high while the RX FIFO is non-empty.

## Operation
Register map (all unlisted bits read 0; addresses 4..15 read 0 and ignore writes):
- 0 DATA
  - Write with sel[3]: push d[24:31] into the TX FIFO. If the FIFO is full, the byte is dropped and TXOVF is set.
  - Read: q[0] = RX non-empty, q[24:31] = RX head (0 when empty). A read with sel[3] and a non-empty FIFO pops the head.
- 1 STATUS
  - q[0] RXNE, q[1] TXFULL, q[2] TXIDLE (TX FIFO empty and shifter idle), q[3] RXOVR, q[4] FRAMERR, q[5] TXOVF.
  - q[8:15] RX count, q[16:23] TX count.
  - Write with sel[0]: writing 1 to any of bits 3..5 clears that flag.
- 2 DIVISOR: q[16:31]. Written per byte lane via sel[2] and sel[3]. Bit period is DIVISOR+1 clocks.
- 3 CONTROL: q[31] LOOPBACK (written via sel[3]). When set, the RX input is taken from internal txd instead of uart_rxd.

FIFOs:
- Each FIFO is a circular buffer of 2^FIFO_LOG2 entries with a FIFO_LOG2+1 bit count.
- A push and a pop in the same cycle are both performed and the count is unchanged.
- A push to a full FIFO is accepted if a pop occurs in the same cycle. No flag is set in that case.

TX state machine (IDLE, START, DATA, STOP):
- IDLE with TX FIFO non-empty: pop the FIFO into the shifter, drive txd=0, go to START.
- START, then 8 DATA bits LSB first, then STOP (txd=1). Each bit lasts DIVISOR+1 cycles.
- At the end of STOP: if the FIFO is non-empty, load the next byte and enter START directly (no idle cycle); otherwise go to IDLE.

RX state machine (IDLE, START, DATA, STOP):
- The input passes through a 2-FF synchroniser reset to 1.
- IDLE: a synchronised falling edge moves to START and loads the counter with (DIVISOR+1)/2.
- START: at expiry, if the input is still low, go to DATA; otherwise it was a false start, return to IDLE.
- DATA: sample 8 bits LSB first, one every DIVISOR+1 cycles.
- STOP: sample the stop bit.
  - Stop bit 1: push the byte. If the FIFO is full (and no pop occurs in the same cycle), drop the byte and set RXOVR.
  - Stop bit 0: discard the byte and set FRAMERR.
  - Either way, return to IDLE.
- The RX path requires DIVISOR >= 3.

Divisor changes take effect at the next bit-counter reload; a frame already in progress is not restarted.

## Timing
- Reset values:
  - uart_txd=1, irq=0.
  - Both FIFOs empty, both FSMs in IDLE, all flags 0.
  - DIVISOR=DIV_RESET, LOOPBACK=0.
  - q follows the register map: STATUS reads 32'h20000000 (TXIDLE set).
- Reset mid-frame aborts both FSMs immediately. txd returns to 1 on the edge where reset is sampled.
- Register writes and pops take effect on the clock edge that ends the cs cycle.
- TX latency: with the TX FSM idle, a DATA write on edge E gives txd=0 from edge E+1. The frame lasts exactly 10*(DIVISOR+1) cycles.
- RX: a pushed byte is visible in q and irq on the cycle after the edge that sampled the stop bit.
- A flag set and a write-1-clear of the same flag in the same cycle: set wins.

## Test plan
- Reset, then read STATUS -> 32'h20000000; read DIVISOR -> 433; uart_txd=1; irq=0.
- DIVISOR=3, write DATA=0xA5 -> txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4; TXIDLE=1 after 40 cycles.
- DIVISOR=3, LOOPBACK=1, write 0x3C and 0xC3 -> back-to-back frames; RX count reaches 2, irq=1; DATA reads give 0x8000003C then 0x800000C3; irq=0 afterwards.
- Fill the TX FIFO with 16 writes while the TX FSM is still busy, then write a 17th byte -> TXOVF=1 and the 17th byte is never transmitted; writing STATUS=32'h04000000 clears TXOVF.
- Drive uart_rxd with a frame whose stop bit is 0 -> FRAMERR=1 and RX count stays 0. Receive 17 frames without reading -> RXOVR=1 and the FIFO holds the first 16 bytes.
- A 2-cycle low glitch on uart_rxd with DIVISOR=9 -> no push and no flags; RX FSM returns to IDLE.

Source files
------------

// File: rtl/spmmio_uart.sv
`default_nettype none
// ============================================================================
// Module   : spmmio_uart
// Brief    : Memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor,
//            sticky error flags and a level RX interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module spmmio_uart #(
    parameter int FIFO_LOG2 = 4,
    parameter int DIV_RESET = 433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  adr,
    input  logic        cs,
    input  logic [0:3]  sel,
    input  logic        we,
    input  logic [0:31] d,
    output logic [0:31] q,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq
);

    localparam int                   c_DEPTH    = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   c_CNT_FULL = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2:0]   c_CNT_ONE  = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2-1:0] c_PTR_ONE  = c_CNT_ONE[FIFO_LOG2-1:0];

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_wbyte;
    logic       w_stat_wr;

    assign w_wr      = cs & we;
    assign w_rd      = cs & ~we;
    assign w_wbyte   = d[24:31];
    assign w_stat_wr = w_wr && (adr == 4'd1) && sel[0];

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [15:0] r_div;
    logic        r_loop;
    logic [16:0] w_div_p1;
    logic [15:0] w_div_half;

    assign w_div_p1   = {1'b0, r_div} + 17'd1;
    assign w_div_half = w_div_p1[16:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= 16'(DIV_RESET);
            r_loop <= 1'b0;
        end else begin
            if (w_wr && (adr == 4'd2)) begin
                if (sel[2]) r_div[15:8] <= d[16:23];
                if (sel[3]) r_div[7:0]  <= d[24:31];
            end
            if (w_wr && (adr == 4'd3) && sel[3]) r_loop <= d[31];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]           r_tx_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_tx_wp;
    logic [FIFO_LOG2-1:0] r_tx_rp;
    logic [FIFO_LOG2:0]   r_tx_cnt;
    logic                 w_tx_push_req;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic                 w_txovf_set;
    logic [7:0]           w_tx_head;

    assign w_tx_push_req = w_wr && (adr == 4'd0) && sel[3];
    assign w_tx_full     = (r_tx_cnt == c_CNT_FULL);
    assign w_tx_empty    = (r_tx_cnt == '0);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_txovf_set   = w_tx_push_req && w_tx_full && !w_tx_pop;
    assign w_tx_head     = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= w_wbyte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PTR_ONE;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
            else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // TX state machine
    // ------------------------------------------------------------------
    logic [1:0]  r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_timer, w_tx_timer_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic [2:0]  r_tx_bit,   w_tx_bit_nxt;
    logic        r_txd,      w_txd_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= c_S_IDLE;
            r_tx_timer <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_timer <= w_tx_timer_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_timer_nxt = r_tx_timer;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_bit_nxt   = r_tx_bit;
        w_txd_nxt      = r_txd;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            c_S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_txd_nxt      = 1'b0;
                    w_tx_timer_nxt = r_div;
                    w_tx_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                if (r_tx_timer == '0) begin
                    w_txd_nxt      = r_tx_shift[0];
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_timer_nxt = r_div;
                    w_tx_state_nxt = c_S_DATA;
                end else begin
                    w_tx_timer_nxt = r_tx_timer - 16'd1;
                end
            end
            c_S_DATA: begin
                if (r_tx_timer == '0) begin
                    w_tx_timer_nxt = r_div;
                    if (r_tx_bit == 3'd7) begin
                        w_txd_nxt      = 1'b1;
                        w_tx_state_nxt = c_S_STOP;
                    end else begin
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_txd_nxt      = r_tx_shift[1];
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_timer_nxt = r_tx_timer - 16'd1;
                end
            end
            c_S_STOP: begin
                if (r_tx_timer == '0) begin
                    // Chain straight into the next start bit when more data waits
                    if (!w_tx_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_tx_head;
                        w_txd_nxt      = 1'b0;
                        w_tx_timer_nxt = r_div;
                        w_tx_state_nxt = c_S_START;
                    end else begin
                        w_tx_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_tx_timer_nxt = r_tx_timer - 16'd1;
                end
            end
            default: w_tx_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic w_rx_in;
    logic r_rx_sync1;
    logic r_rx_sync2;
    logic r_rx_prev;
    logic w_rx_fall;

    assign w_rx_in   = r_loop ? r_txd : uart_rxd;
    assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= w_rx_in;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]           r_rx_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_rx_wp;
    logic [FIFO_LOG2-1:0] r_rx_rp;
    logic [FIFO_LOG2:0]   r_rx_cnt;
    logic                 w_rx_push_req;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic                 w_rxovr_set;
    logic                 w_ferr_set;
    logic [7:0]           w_rx_head;

    assign w_rx_full   = (r_rx_cnt == c_CNT_FULL);
    assign w_rx_empty  = (r_rx_cnt == '0);
    assign w_rx_pop    = w_rd && (adr == 4'd0) && sel[3] && !w_rx_empty;
    assign w_rx_push   = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_rxovr_set = w_rx_push_req && w_rx_full && !w_rx_pop;
    assign w_rx_head   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];

    // ------------------------------------------------------------------
    // RX state machine
    // ------------------------------------------------------------------
    logic [1:0]  r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_timer, w_rx_timer_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic [2:0]  r_rx_bit,   w_rx_bit_nxt;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PTR_ONE;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
            else if (w_rx_pop && !w_rx_push) r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= c_S_IDLE;
            r_rx_timer <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_timer <= w_rx_timer_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_timer_nxt = r_rx_timer;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_push_req  = 1'b0;
        w_ferr_set     = 1'b0;
        case (r_rx_state)
            c_S_IDLE: begin
                // Half a bit period puts later samples near mid-bit
                if (w_rx_fall) begin
                    w_rx_timer_nxt = w_div_half;
                    w_rx_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                if (r_rx_timer == '0) begin
                    if (!r_rx_sync2) begin
                        w_rx_timer_nxt = r_div;
                        w_rx_bit_nxt   = 3'd0;
                        w_rx_state_nxt = c_S_DATA;
                    end else begin
                        w_rx_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_rx_timer_nxt = r_rx_timer - 16'd1;
                end
            end
            c_S_DATA: begin
                if (r_rx_timer == '0) begin
                    w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[7:1]};
                    w_rx_timer_nxt = r_div;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = c_S_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_timer_nxt = r_rx_timer - 16'd1;
                end
            end
            c_S_STOP: begin
                if (r_rx_timer == '0) begin
                    if (r_rx_sync2) w_rx_push_req = 1'b1;
                    else            w_ferr_set    = 1'b1;
                    w_rx_state_nxt = c_S_IDLE;
                end else begin
                    w_rx_timer_nxt = r_rx_timer - 16'd1;
                end
            end
            default: w_rx_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    logic r_rxovr;
    logic r_ferr;
    logic r_txovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxovr <= 1'b0;
            r_ferr  <= 1'b0;
            r_txovf <= 1'b0;
        end else begin
            r_rxovr <= w_rxovr_set | (r_rxovr & ~(w_stat_wr & d[3]));
            r_ferr  <= w_ferr_set  | (r_ferr  & ~(w_stat_wr & d[4]));
            r_txovf <= w_txovf_set | (r_txovf & ~(w_stat_wr & d[5]));
        end
    end

    // ------------------------------------------------------------------
    // Read mux (numeric bit 31 is the bus MSB q[0])
    // ------------------------------------------------------------------
    logic [31:0] w_q;
    logic        w_tx_idle;

    assign w_tx_idle = w_tx_empty && (r_tx_state == c_S_IDLE);

    always_comb begin
        w_q = '0;
        case (adr)
            4'd0: begin
                w_q[31]  = !w_rx_empty;
                w_q[7:0] = w_rx_head;
            end
            4'd1: begin
                w_q[31]    = !w_rx_empty;
                w_q[30]    = w_tx_full;
                w_q[29]    = w_tx_idle;
                w_q[28]    = r_rxovr;
                w_q[27]    = r_ferr;
                w_q[26]    = r_txovf;
                w_q[23:16] = 8'(r_rx_cnt);
                w_q[15:8]  = 8'(r_tx_cnt);
            end
            4'd2:    w_q[15:0] = r_div;
            4'd3:    w_q[0]    = r_loop;
            default: w_q = '0;
        endcase
    end

    assign q        = w_q;
    assign uart_txd = r_txd;
    assign irq      = !w_rx_empty;

    logic w_unused;
    assign w_unused = ^{d[0:2], d[6:15], sel[1], w_div_p1[0]};

endmodule
`default_nettype wire
